miriscv_dmem: RTL

Byte-enabled, word-organised data memory sitting directly downstream of the core's load/store unit on its memory-side bus. Accepts one request at a time, inserts a configurable number of wait states, then returns a one-cycle `data_ready_o` pulse with registered read data. The LSU uses that pulse to release the core stall. Out-of-range accesses are flagged, not serviced.

---
 rtl/miriscv_dmem.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/miriscv_dmem.sv
// miriscv_dmem: byte-enabled, word-organised data memory behind the LSU.
// Latency: response pulse WAIT_STATES+1 cycles after acceptance; one access in flight.
// Backpressure: a new request is taken only in IDLE; inputs are ignored until the FSM returns there.
//
// Ports:
//   clk_i, arstn_i          clock and synchronous active-low reset
//   data_req_i/we/be/addr/wdata   request from the LSU (req held until ready)
//   data_rdata_o            registered read word, held between responses
//   data_ready_o            one-cycle response pulse
//   data_err_o              out-of-range flag, only ever high together with ready
module miriscv_dmem #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_ready_o,
  output logic        data_err_o
);

  localparam int          IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [2:0]  WS    = 3'(WAIT_STATES);
  // Upper bound computed in 33 bits so a window ending at 4 GiB does not wrap.
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  // Fields used at the commit edge. With zero wait states the commit edge is
  // the acceptance edge itself, so the live inputs stand in for the latches.
  logic             c_we;
  logic [3:0]       c_be;
  logic [31:0]      c_addr;
  logic [31:0]      c_wdata;
  logic [31:0]      c_off;
  logic [IDX_W-1:0] c_idx;
  logic             c_in_range;
  logic             commit;
  logic             mem_we;

  always_comb begin
    c_we    = we_q;
    c_be    = be_q;
    c_addr  = addr_q;
    c_wdata = wdata_q;
    if (state_q == ST_IDLE) begin
      c_we    = data_we_i;
      c_be    = data_be_i;
      c_addr  = data_addr_i;
      c_wdata = data_wdata_i;
    end
    c_off      = c_addr - BASE_ADDR;
    c_idx      = IDX_W'(c_off >> 2);
    c_in_range = ({1'b0, c_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, c_addr} < LIMIT);
    // A reset on the would-be commit edge suppresses the access entirely.
    commit     = arstn_i &&
                 (((state_q == ST_IDLE) && data_req_i && (WS == 3'd0)) ||
                  ((state_q == ST_WAIT) && (cnt_q == 3'd1)));
    mem_we     = commit && c_in_range && c_we;
  end

  // Next-state and request-register logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (data_req_i) begin
          we_d    = data_we_i;
          be_d    = data_be_i;
          addr_d  = data_addr_i;
          wdata_d = data_wdata_i;
          cnt_d   = WS;
          state_d = (WS == 3'd0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Response data: loads capture the word, stores leave the previous value,
  // out-of-range accesses return zero with the error flag.
  always_comb begin
    rdata_d = rdata_q;
    err_d   = 1'b0;
    if (commit) begin
      err_d = !c_in_range;
      if (!c_in_range) begin
        rdata_d = 32'h0;
      end else if (!c_we) begin
        rdata_d = mem[c_idx];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      we_q    <= 1'b0;
      be_q    <= 4'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately not cleared by reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (c_be[k]) begin
          mem[c_idx][8*k +: 8] <= c_wdata[8*k +: 8];
        end
      end
    end
  end

  // Outputs: decoded from flops only.
  always_comb begin
    data_ready_o = (state_q == ST_RESP);
    data_err_o   = err_q;
    data_rdata_o = rdata_q;
  end

endmodule
